// File: rtl/ram_stage_pkg.sv
// Shared types, default sizes and the youngest-match helper for the RAM write staging queue.
package ram_stage_pkg;

    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned INDEX_DEF  = 6;
    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned QDEPTH_DEF = 4;
    localparam int unsigned QINDEX_DEF = 2;

    // Helper works on vectors sized for the largest supported queue.
    localparam int unsigned QDEPTH_MAX = 16;
    localparam int unsigned QINDEX_MAX = 4;

    typedef struct packed {
        logic                 valid;
        logic [INDEX_DEF-1:0] addr;
        logic [WIDTH_DEF-1:0] data;
    } stageEntry_t;

    // Walks from tail (oldest slot when full) forward to tail-1, so the last hit is the youngest.
    function automatic logic [QINDEX_MAX-1:0] youngestMatch(
        input logic [QDEPTH_MAX-1:0] valid,
        input logic [QDEPTH_MAX-1:0] match,
        input logic [QINDEX_MAX-1:0] tail,
        input logic [QINDEX_MAX-1:0] mask
    );
        logic [QINDEX_MAX-1:0] idx;
        logic [QINDEX_MAX-1:0] sel;
        sel = '0;
        for (int k = 0; k < int'(QDEPTH_MAX); k++) begin
            idx = (tail + QINDEX_MAX'(k)) & mask;
            if (valid[idx] && match[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/ram_stage_fwd_cam.sv
// Combinational address compare over the staging entries with youngest-entry priority select.
module ram_stage_fwd_cam
    import ram_stage_pkg::*;
#(
    parameter int unsigned INDEX  = INDEX_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned QDEPTH = QDEPTH_DEF,
    parameter int unsigned QINDEX = QINDEX_DEF
) (
    input  logic [QDEPTH-1:0]            valid_i,
    input  logic [QDEPTH-1:0][INDEX-1:0] addr_i,
    input  logic [QDEPTH-1:0][WIDTH-1:0] data_i,
    input  logic [QINDEX-1:0]            tail_i,
    input  logic [INDEX-1:0]             key_i,
    output logic                         hit_o,
    output logic [QINDEX-1:0]            idx_o,
    output logic [WIDTH-1:0]             data_o
);

    logic [QDEPTH-1:0]     match;
    logic [QDEPTH_MAX-1:0] valid_ext;
    logic [QDEPTH_MAX-1:0] match_ext;
    logic [QINDEX_MAX-1:0] sel;

    always_comb begin
        match     = '0;
        valid_ext = '0;
        match_ext = '0;
        for (int i = 0; i < int'(QDEPTH); i++) begin
            match[i] = valid_i[i] && (addr_i[i] == key_i);
        end
        valid_ext[QDEPTH-1:0] = valid_i;
        match_ext[QDEPTH-1:0] = match;
        sel    = youngestMatch(valid_ext, match_ext, QINDEX_MAX'(tail_i), QINDEX_MAX'(QDEPTH - 1));
        idx_o  = QINDEX'(sel);
        hit_o  = |match;
        data_o = hit_o ? data_i[idx_o] : '0;
    end

endmodule

// File: rtl/ram_wr_stage_queue.sv
// In-order write staging queue in front of a 1R1W RAM, with read forwarding of pending writes.
// Optional build macro WR_COALESCE_EN merges a write into a pending entry with the same address.
module ram_wr_stage_queue
    import ram_stage_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned INDEX  = INDEX_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned QDEPTH = QDEPTH_DEF,
    parameter int unsigned QINDEX = QINDEX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enqValid_i,
    input  logic [INDEX-1:0]  enqAddr_i,
    input  logic [WIDTH-1:0]  enqData_i,
    output logic              enqReady_o,
    input  logic              drainStall_i,
    output logic              we_o,
    output logic [INDEX-1:0]  addrWr_o,
    output logic [WIDTH-1:0]  data_o,
    input  logic [INDEX-1:0]  lkAddr_i,
    output logic              lkHit_o,
    output logic [WIDTH-1:0]  lkData_o,
    output logic [QINDEX:0]   count_o,
    output logic              empty_o
);

    localparam int unsigned CW = QINDEX + 1;

    if (DEPTH != (1 << INDEX) || QDEPTH != (1 << QINDEX) || QDEPTH < 2 || QDEPTH > QDEPTH_MAX) begin : g_bad_params
        $error("ram_wr_stage_queue: inconsistent DEPTH/INDEX/QDEPTH/QINDEX");
    end

    logic [QDEPTH-1:0]            valid_q, valid_d;
    logic [QDEPTH-1:0][INDEX-1:0] addr_q, addr_d;
    logic [QDEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [QINDEX-1:0]            head_q, head_d;
    logic [QINDEX-1:0]            tail_q, tail_d;
    logic [CW-1:0]                count_q, count_d;

    logic full;
    logic head_valid;
    logic coalesce;
    logic enq_fire;
    logic alloc;
    logic [QINDEX-1:0] co_idx;

    assign full       = (count_q == CW'(QDEPTH));
    assign head_valid = valid_q[head_q];
    assign we_o       = head_valid && !drainStall_i;
    assign addrWr_o   = head_valid ? addr_q[head_q] : '0;
    assign data_o     = head_valid ? data_q[head_q] : '0;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    ram_stage_fwd_cam #(
        .INDEX (INDEX),
        .WIDTH (WIDTH),
        .QDEPTH(QDEPTH),
        .QINDEX(QINDEX)
    ) u_fwd_cam (
        .valid_i(valid_q),
        .addr_i (addr_q),
        .data_i (data_q),
        .tail_i (tail_q),
        .key_i  (lkAddr_i),
        .hit_o  (lkHit_o),
        .idx_o  (),
        .data_o (lkData_o)
    );

`ifdef WR_COALESCE_EN
    logic             co_hit;
    logic [WIDTH-1:0] co_data;

    ram_stage_fwd_cam #(
        .INDEX (INDEX),
        .WIDTH (WIDTH),
        .QDEPTH(QDEPTH),
        .QINDEX(QINDEX)
    ) u_coalesce_cam (
        .valid_i(valid_q),
        .addr_i (addr_q),
        .data_i (data_q),
        .tail_i (tail_q),
        .key_i  (enqAddr_i),
        .hit_o  (co_hit),
        .idx_o  (co_idx),
        .data_o (co_data)
    );

    // A head entry leaving this cycle cannot absorb new data; allocate behind it instead.
    assign coalesce = co_hit && !((co_idx == head_q) && we_o);
`else
    assign coalesce = 1'b0;
    assign co_idx   = '0;
`endif

    // Handshake: a request transfers on any cycle with enqValid_i && enqReady_o; the producer holds
    // addr/data stable until then. Ready looks only at occupancy, except that a coalescing write is
    // taken even when full.
    assign enqReady_o = !full || (enqValid_i && coalesce);
    assign enq_fire   = enqValid_i && enqReady_o;
    assign alloc      = enq_fire && !coalesce;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (we_o) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + QINDEX'(1);
        end
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = enqAddr_i;
            data_d[tail_q]  = enqData_i;
            tail_d          = tail_q + QINDEX'(1);
        end
        if (enq_fire && coalesce) begin
            data_d[co_idx] = enqData_i;
        end
        case ({alloc, we_o})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/ram_wr_stage_queue.md
Name: ram_wr_stage_queue

Overview:
- Write-side initiator for a 1R1W RAM with one write port (synchronous write, asynchronous read).
- Accepts one write request per cycle from a producer and buffers it in a small in-order queue.
- Drains one entry per cycle onto the RAM write port unless stalled.
- Provides a read-forwarding lookup so a RAM reader sees pending (not-yet-written) data.

Parameters:
- DEPTH, 64, entries in the target RAM.
- INDEX, 6, RAM address width (log2 DEPTH).
- WIDTH, 32, data width.
- QDEPTH, 4, staging queue entries; must be a power of two, at least 2.
- QINDEX, 2, log2 QDEPTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- enqValid_i  in  1  producer write request.
- enqAddr_i  in  INDEX  request address.
- enqData_i  in  WIDTH  request data.
- enqReady_o  out  1  queue can accept this cycle.
- drainStall_i  in  1  RAM write port unavailable this cycle.
- we_o  out  1  RAM write enable.
- addrWr_o  out  INDEX  RAM write address.
- data_o  out  WIDTH  RAM write data.
- lkAddr_i  in  INDEX  forwarding lookup address (the RAM read address).
- lkHit_o  out  1  a pending entry matches lkAddr_i.
- lkData_o  out  WIDTH  data of the youngest matching entry; 0 when no hit.
- count_o  out  QINDEX+1  occupied entries.
- empty_o  out  1  count_o == 0.

Behaviour:
- State: per-entry valid, addr and data registers; head and tail pointers of QINDEX bits; count of QINDEX+1 bits.
- Reset asserted: clear all valids, head, tail and count to 0 immediately, without waiting for clk. Entry addr/data are cleared to 0.
  - Output values under reset: we_o=0, addrWr_o=0, data_o=0, lkHit_o=0, lkData_o=0, count_o=0, empty_o=1, enqReady_o=1.
  - Reset asserted mid-drain discards all pending writes; no partial write is issued.
- Enqueue fires when enqValid_i && enqReady_o.
  - enqReady_o = (count != QDEPTH).
  - enqReady_o is combinational from state only; it does not depend on a same-cycle dequeue. When full, enqueue is refused even if a drain occurs that cycle.
  - On fire: entry[tail] <= {1, addr, data}; tail increments modulo QDEPTH.
- Drain outputs are driven combinationally from registered head state:
  - we_o = valid[head] && !drainStall_i.
  - addrWr_o / data_o = entry[head] fields when valid, else 0.
  - On we_o: clear valid[head]; head increments modulo QDEPTH.
- Latency: a request enqueued in cycle N, with the queue empty and no stall, appears on we_o in cycle N+1. The RAM holds the data after the edge ending N+1.
- Ordering: writes reach the RAM strictly in enqueue order. Duplicate addresses are all written, oldest first.
- count updates: enqueue only, +1; drain only, -1; both in the same cycle, unchanged.
- Pointer wrap: tail and head wrap from QDEPTH-1 to 0. Full and empty are distinguished by count, not by pointer equality.
- Forwarding (combinational):
  - Search all valid entries for addr == lkAddr_i.
  - On a match, return the youngest, i.e. nearest tail going backwards. The entry being drained this cycle still counts as pending.
  - A same-cycle enqueue is not visible until the next cycle.
- drainStall_i while empty: no effect.

Optional Feature:
- Macro WR_COALESCE_EN.
- Defined:
  - An enqueue whose address matches a valid entry overwrites that entry's data in place; no allocation, tail and count unchanged.
  - Exception: if the matching entry is the head and we_o is high this cycle, the request allocates normally instead.
  - A coalescing enqueue is accepted even when full, so enqReady_o = !full || (enqValid_i && coalescible match).
- Undefined: every enqueue allocates, as described above.

Decomposition:
- Shared package ram_stage_pkg holds:
  - typedef stageEntry_t {valid, addr[INDEX], data[WIDTH]};
  - localparam defaults for QDEPTH/QINDEX;
  - a function youngestMatch(valid vector, match vector, tail) returning the index.
- One sub-module fits naturally: ram_stage_fwd_cam, the combinational address compare plus youngest-priority select. It is shared by forwarding and by coalesce match detection.

Test Plan:
- Reset then idle: release reset -> we_o=0, empty_o=1, count_o=0, enqReady_o=1, lkHit_o=0.
- Single write: enqueue addr 5 / data 0xDEADBEEF in cycle 1, no stall -> cycle 2 we_o=1, addrWr_o=5, data_o=0xDEADBEEF; cycle 3 empty_o=1.
- Fill and backpressure: drainStall_i=1, enqueue 5 requests to addrs 1..5 -> first 4 accepted, count_o=4, enqReady_o=0 on the 5th. Release stall -> writes 1,2,3,4 in order on 4 consecutive cycles.
- Forwarding: stall; enqueue (7,0x11) then (7,0x22); lkAddr_i=7 -> lkHit_o=1, lkData_o=0x22. lkAddr_i=8 -> lkHit_o=0, lkData_o=0.
- Wrap plus simultaneous enqueue/drain: stream 10 back-to-back enqueues, no stall -> count_o holds at 1, pointers wrap, RAM receives all 10 in order.
- Async reset mid-operation: count_o=3 while stalled; pulse reset low between edges -> outputs clear immediately. After release no stale write appears on we_o.
- With WR_COALESCE_EN: stall; enqueue (9,0xA) then (9,0xB) -> count_o=1. Unstall -> a single write of 9 / 0xB.
